// File: rtl/bufferram_out_streamer_pkg.sv
// Shared constants and types for the output-buffer RAM port-2 streamer.
package bufferram_out_streamer_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned MAX_WORDS = 96000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } fifo_entry_t;

endpackage

// File: rtl/bufferram_out_stream_fifo.sv
// First-word-fall-through FIFO of tagged stream words, with occupancy count and flush.
module bufferram_out_stream_fifo
  import bufferram_out_streamer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  output fifo_entry_t rdata,
  output logic [PtrW:0] count
);

  fifo_entry_t         mem [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       count_q;
  logic                pop_ok;

  assign pop_ok = pop && (count_q != '0);
  assign rdata  = mem[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bufferram_out_streamer.sv
// Reads a frame from output-buffer RAM port 2 and emits it as a back-pressured
// packet stream; reads are credit-limited so the output FIFO can never overflow.
module bufferram_out_streamer #(
  parameter int unsigned DATA_W     = bufferram_out_streamer_pkg::DATA_W,
  parameter int unsigned ADDR_W     = bufferram_out_streamer_pkg::ADDR_W,
  parameter int unsigned MAX_WORDS  = bufferram_out_streamer_pkg::MAX_WORDS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] frame_len,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              done
);
  import bufferram_out_streamer_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] len_clamped, last_addr;
  logic              inflight_q, inf_sop_q, inf_eop_q;
  logic              done_q, done_d;
  logic [CntW-1:0]   fifo_count, occupancy;
  fifo_entry_t       head, push_entry;
  logic              issue, xfer, eop_xfer, kill;

  assign len_clamped = (frame_len > ADDR_W'(MAX_WORDS)) ? ADDR_W'(MAX_WORDS) : frame_len;
  assign last_addr   = len_q - ADDR_W'(1);
  assign kill        = abort && (state_q != StIdle);

  // Credits count the read still in the RAM pipeline, not just FIFO contents.
  assign occupancy = fifo_count + CntW'(inflight_q);
  assign issue     = (state_q == StRun) && (occupancy < CntW'(FIFO_DEPTH)) && !abort;

  assign st_valid = (fifo_count != '0);
  assign st_data  = st_valid ? head.data : '0;
  assign st_sop   = st_valid && head.sop;
  assign st_eop   = st_valid && head.eop;
  assign xfer     = st_valid && st_ready;
  assign eop_xfer = xfer && head.eop;

  assign ram_address    = addr_q;
  assign ram_chipselect = issue;
  assign ram_clken      = 1'b1;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

  assign push_entry = '{data: ram_readdata, sop: inf_sop_q, eop: inf_eop_q};

  bufferram_out_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (kill),
    .push  (inflight_q),
    .wdata (push_entry),
    .pop   (xfer),
    .rdata (head),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort && (len_clamped != '0)) begin
          len_d   = len_clamped;
          addr_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          if (addr_q == last_addr) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (eop_xfer) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = loop_en ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (kill) begin
      state_d = StIdle;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
      inf_sop_q  <= 1'b0;
      inf_eop_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      inflight_q <= issue;
      inf_sop_q  <= (addr_q == '0);
      inf_eop_q  <= (addr_q == last_addr);
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_bufferram_out_streamer.sv
// Self-checking bench: frame table plus directed latency, loop, abort and reset sequences.
// RAM depth is overridden to a small value so the length clamp is reachable in a short run.
module tb_bufferram_out_streamer;

  localparam int TbMax   = 40;
  localparam int FifoDep = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, loop_en;
  logic [16:0] frame_len;
  logic [16:0] ram_address;
  logic        ram_chipselect, ram_clken;
  logic [15:0] ram_readdata;
  logic [15:0] st_data;
  logic        st_valid, st_ready, st_sop, st_eop, busy, done;

  always #5 clk = ~clk;

  bufferram_out_streamer #(
    .DATA_W     (16),
    .ADDR_W     (17),
    .MAX_WORDS  (TbMax),
    .FIFO_DEPTH (FifoDep)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .loop_en        (loop_en),
    .frame_len      (frame_len),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .busy           (busy),
    .done           (done)
  );

  // RAM model: RAM[i] = 0x1000 + i, one-cycle read latency.
  always @(posedge clk) ram_readdata <= 16'h1000 + ram_address[15:0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  word_t got_q[$];
  int    done_cnt = 0;
  int    cs_cnt   = 0;
  int    issued   = 0;
  int    popped   = 0;
  int    ready_mode = 0;

  logic        prev_stall = 1'b0, prev_kill = 1'b0;
  logic [17:0] prev_word  = '0;

  // Stream monitor: records transfers, checks stall stability and read credits.
  always @(negedge clk) begin
    if (prev_stall && !prev_kill) begin
      chk("stall_valid", st_valid, 1);
      chk("stall_hold", {st_data, st_sop, st_eop}, prev_word);
    end
    prev_stall = st_valid && !st_ready;
    prev_kill  = reset || (abort && busy);
    prev_word  = {st_data, st_sop, st_eop};
    if (st_valid && st_ready) got_q.push_back('{st_data, st_sop, st_eop});
    if (done) done_cnt++;
    if (reset || (abort && busy)) begin
      issued = 0;
      popped = 0;
    end else begin
      if (ram_chipselect) begin
        chk("credit", (issued + 1 - popped) <= FifoDep, 1);
        issued++;
        cs_cnt++;
      end
      if (st_valid && st_ready) popped++;
    end
  end

  initial begin
    int phase = 0;
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: st_ready = 1'b1;
        1: begin
          st_ready = (phase == 0);
          phase    = (phase + 1) % 3;
        end
        default: st_ready = 1'b0;
      endcase
    end
  end

  task automatic clear_log();
    got_q.delete();
    done_cnt = 0;
    cs_cnt   = 0;
  endtask

  task automatic start_frame(input logic [16:0] len, input logic lp);
    @(posedge clk); #1;
    frame_len = len;
    loop_en   = lp;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frames(input int nframes, input int flen, input string name);
    int total = nframes * flen;
    chk({name, "_count"}, got_q.size(), total);
    for (int i = 0; i < total && i < got_q.size(); i++) begin
      chk({name, "_data"}, got_q[i].data, 32'h1000 + (i % flen));
      chk({name, "_sop"}, got_q[i].sop, (i % flen) == 0);
      chk({name, "_eop"}, got_q[i].eop, (i % flen) == flen - 1);
    end
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_valid"}, st_valid, 0);
    chk({name, "_data"}, st_data, 0);
    chk({name, "_sop"}, st_sop, 0);
    chk({name, "_eop"}, st_eop, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_cs"}, ram_chipselect, 0);
    chk({name, "_addr"}, ram_address, 0);
    chk({name, "_clken"}, ram_clken, 1);
  endtask

  typedef struct {
    logic [16:0] len;
    int          mode;
    int          exp_words;
    int          exp_done;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{17'd5, 0, 5, 1};
    vecs[1] = '{17'd5, 1, 5, 1};
    vecs[2] = '{17'd1, 1, 1, 1};
    vecs[3] = '{17'd0, 0, 0, 0};
    vecs[4] = '{17'h1FFFF, 0, TbMax, 1};
    vecs[5] = '{17'(TbMax + 1), 1, TbMax, 1};
    vecs[6] = '{17'(TbMax), 0, TbMax, 1};
    vecs[7] = '{17'd2, 1, 2, 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; frame_len = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Exact latency: start in cycle 0, words in cycles 3..7, done in cycle 8.
    clear_log();
    @(posedge clk); #1;
    frame_len = 17'd5; loop_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat_c1_cs", ram_chipselect, 1);
    chk("lat_c1_addr", ram_address, 0);
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("lat_c%0d_valid", c), st_valid, (c >= 3 && c <= 7));
      if (c >= 3 && c <= 7) begin
        chk($sformatf("lat_c%0d_data", c), st_data, 32'h1000 + c - 3);
        chk($sformatf("lat_c%0d_sop", c), st_sop, c == 3);
        chk($sformatf("lat_c%0d_eop", c), st_eop, c == 7);
      end
      chk($sformatf("lat_c%0d_done", c), done, c == 8);
      if (c == 9) chk("lat_c9_busy", busy, 0);
    end

    // Frame table.
    foreach (vecs[k]) begin
      ready_mode = vecs[k].mode;
      clear_log();
      start_frame(vecs[k].len, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_busy", k), busy, vecs[k].exp_words != 0);
      wait_idle(400, $sformatf("vec%0d", k));
      check_frames(1, vecs[k].exp_words, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_done_cnt", k), done_cnt, vecs[k].exp_done);
      chk($sformatf("vec%0d_reads", k), cs_cnt, vecs[k].exp_words);
    end

    // Loop mode: three frames of 3 words, loop_en dropped during the third.
    begin
      int n = 0;
      ready_mode = 0;
      clear_log();
      start_frame(17'd3, 1'b1);
      while (done_cnt < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("loop_two_done_timeout", done_cnt >= 2, 1);
      @(posedge clk); #1;
      loop_en = 1'b0;
      wait_idle(200, "loop");
      check_frames(3, 3, "loop");
      chk("loop_done_cnt", done_cnt, 3);
    end

    // Abort mid-frame after two transfers.
    begin
      int n = 0;
      ready_mode = 0;
      clear_log();
      start_frame(17'd10, 1'b0);
      while (got_q.size() < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("abort_two_words_timeout", got_q.size() >= 2, 1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", st_valid, 0);
      chk("abort_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_still_idle", busy, 0);

      // abort together with start in idle: abort wins.
      @(posedge clk); #1;
      frame_len = 17'd5; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_wins_busy", busy, 0);

      clear_log();
      start_frame(17'd3, 1'b0);
      wait_idle(100, "after_abort");
      check_frames(1, 3, "after_abort");
      chk("after_abort_done", done_cnt, 1);
    end

    // Reset mid-frame with a full FIFO.
    ready_mode = 2;
    clear_log();
    start_frame(17'd10, 1'b0);
    repeat (8) @(negedge clk);
    chk("full_valid", st_valid, 1);
    chk("full_head", st_data, 32'h1000);
    chk("full_no_read", ram_chipselect, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    ready_mode = 0;
    clear_log();
    start_frame(17'd3, 1'b0);
    wait_idle(100, "after_reset");
    check_frames(1, 3, "after_reset");
    chk("after_reset_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
